rv_namec_mem_arbiter: RTL and testbench
=======================================

# rv_namec_mem_arbiter

Single-port memory arbiter for the rv_namec core. It shares one memory bus between the instruction-fetch unit (IF) and the load/store unit (LSU). It grants one outstanding transaction at a time with round-robin priority, routes the response back to the owner, and retires hung transactions with an error response after a programmable timeout. It sits between the core pipeline and the memory model instantiated in rv_namec_tb_top.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT, 255, cycles to wait for a response before error retirement (1..2^16-1)
- rv_namec_mem_arbiter_clock  in  1  single clock, rising edge
- rv_namec_mem_arbiter_reset_n  in  1  asynchronous, active-low reset
- if_req / lsu_req  in  1  request, held with its payload until the matching gnt
- if_addr / lsu_addr  in  ADDR_W  address
- if_we / lsu_we  in  1  write enable (IF drives 0)
- if_wstrb / lsu_wstrb  in  DATA_W/8  byte strobes
- if_wdata / lsu_wdata  in  DATA_W  write data
- if_gnt / lsu_gnt  out  1  request accepted by memory
- if_rvalid / lsu_rvalid  out  1  one-cycle response pulse
- if_rdata / lsu_rdata  out  DATA_W  read data, 0 when rvalid is low
- if_err / lsu_err  out  1  valid with rvalid; 1 means timeout
- mem_req  out  1  request to memory
- mem_addr, mem_we, mem_wstrb, mem_wdata  out  as above  owner's payload, 0 when mem_req is low
- mem_gnt  in  1  memory accepts the request
- mem_rvalid  in  1  response pulse
- mem_rdata  in  DATA_W  response data

## Operation
- States: IDLE, ADDR, RESP.
- IDLE
  - If no request is pending, stay in IDLE.
  - If only one requester asserts req, it becomes owner.
  - If both assert req, the requester that is not last_owner wins.
  - On a win, register owner and last_owner <= owner, then go to ADDR.
- ADDR
  - mem_req = 1. mem_* carries the owner's live payload (combinational mux).
  - On mem_gnt, owner gnt = 1 in the same cycle, and the state goes to RESP with timer cleared.
  - If the owner drops req before gnt, abort to IDLE. No gnt is issued and no response is returned.
- RESP
  - mem_req = 0. Timer increments each cycle.
  - On mem_rvalid, owner rvalid = 1 and rdata = mem_rdata, with err = 0. Go to IDLE.
  - If the timer reaches TIMEOUT-1 without mem_rvalid, owner rvalid = 1, err = 1, rdata = 0. Go to IDLE.
  - If mem_rvalid and timeout occur in the same cycle, the real response wins (err = 0).
- Non-owner outputs are always 0.
- mem_rvalid outside RESP is ignored and is not forwarded.
- A write returns a response like a read; rdata is forwarded as-is.
- Reset, asynchronous and valid at any point including mid-transaction:
  - state = IDLE, owner = IF, last_owner = IF (so LSU wins the first tie), timer = 0.
  - Every output is 0 immediately.
  - An in-flight transaction is discarded without a response.

## Timing
- Request sampled in IDLE at cycle 0 gives mem_req = 1 at cycle 1.
- With mem_gnt at cycle 1, gnt is seen at cycle 1 and the arbiter is in RESP from cycle 2.
- mem_rvalid at cycle N gives owner rvalid at cycle N (combinational). IDLE is reached at N+1 and the next grant's mem_req at N+2.
- Minimum back-to-back spacing is 3 cycles per transaction (IDLE, ADDR, RESP).
- Timeout: with mem_gnt at cycle g, the error rvalid pulses at cycle g+TIMEOUT.
- gnt, rvalid, rdata, err and all mem_* outputs are combinational from state and inputs. Every other signal is registered.
- The timer is clog2(TIMEOUT+1) bits and saturates; no wrap-around is possible.

## Structure
- Package rv_namec_mem_pkg holds:
  - state enum (IDLE, ADDR, RESP)
  - owner enum (OWN_IF, OWN_LSU)
  - default ADDR_W/DATA_W localparams, shared with the LSU and fetch units
- Sub-module rv_namec_bus_timer holds the clear/enable/saturating counter with expire flag. It is reused by later bus masters.

## Test plan
- Reset release, then IF reads 0x100 with mem_gnt immediate and mem_rvalid 2 cycles later with 0xDEADBEEF:
  - mem_req at cycle 1, if_gnt at cycle 1
  - if_rvalid with if_rdata = 0xDEADBEEF, err = 0
  - lsu outputs stay 0
- IF and LSU both request in the same cycle after reset:
  - LSU is granted first, then IF
  - repeating the pair 4 times alternates the grants LSU, IF, LSU, IF
- LSU write to 0x200, wdata 0x12345678, wstrb 0xF, with mem_gnt delayed 3 cycles:
  - mem_* stable and equal to the LSU payload for those 3 cycles
  - lsu_gnt pulses exactly once
- TIMEOUT = 8 with no mem_rvalid:
  - lsu_rvalid = 1, lsu_err = 1, lsu_rdata = 0 exactly 8 cycles after gnt
  - a late mem_rvalid afterwards is not forwarded
- reset_n asserted while in RESP:
  - all outputs drop to 0 asynchronously
  - after release, an IF request completes normally
- IF drops req while in ADDR:
  - the arbiter returns to IDLE with no if_gnt and no if_rvalid
  - a pending LSU request is granted next

Source files
------------

// File: rtl/rv_namec_mem_pkg.sv
// rv_namec_mem_pkg: shared memory-bus types and default widths for the rv_namec core.
package rv_namec_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ADDR, RESP} arb_state_e;
    typedef enum logic {OWN_IF, OWN_LSU} owner_e;

endpackage

// File: rtl/rv_namec_mem_arbiter_if.sv
// rv_namec_mem_arbiter_if: IF/LSU request ports and the shared memory bus.
interface rv_namec_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_we;
    logic [DATA_W/8-1:0] if_wstrb;
    logic [DATA_W-1:0] if_wdata;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              lsu_req;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_we;
    logic [DATA_W/8-1:0] lsu_wstrb;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_gnt;
    logic              lsu_rvalid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_err;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  if_req, if_addr, if_we, if_wstrb, if_wdata,
        input  lsu_req, lsu_addr, lsu_we, lsu_wstrb, lsu_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        output mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata
    );

    // requesters and memory side
    modport master (
        output if_req, if_addr, if_we, if_wstrb, if_wdata,
        output lsu_req, lsu_addr, lsu_we, lsu_wstrb, lsu_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        input  mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata
    );

endinterface

// File: rtl/rv_namec_bus_timer.sv
// rv_namec_bus_timer: clearable, saturating cycle counter that flags when LIMIT-1 is reached.
module rv_namec_bus_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = clr_i ? '0 : (en_i && cnt_q != W'(LIMIT)) ? cnt_q + 1'b1 : cnt_q;
        expire_o = cnt_q >= W'(LIMIT - 1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rv_namec_mem_arbiter.sv
// rv_namec_mem_arbiter: round-robin single-outstanding arbiter sharing one memory bus
// between instruction fetch and the LSU, with timeout retirement of hung responses.
module rv_namec_mem_arbiter
    import rv_namec_mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int TIMEOUT = 255
) (
    input logic rv_namec_mem_arbiter_clock,
    input logic rv_namec_mem_arbiter_reset_n,
    rv_namec_mem_arbiter_if.slave bus
);

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d, last_q, last_d;

    logic                tmr_clr, tmr_en, tmr_exp;
    logic                own_req, own_gnt, own_rvalid, own_err;
    logic [DATA_W-1:0]   own_rdata;
    logic [ADDR_W-1:0]   addr_sel;
    logic                we_sel;
    logic [DATA_W/8-1:0] wstrb_sel;
    logic [DATA_W-1:0]   wdata_sel;

    // Payload follows the owner's live inputs; request is withdrawn as soon as the owner drops req.
    always_comb begin
        own_req        = owner_q == OWN_LSU ? bus.lsu_req   : bus.if_req;
        addr_sel       = owner_q == OWN_LSU ? bus.lsu_addr  : bus.if_addr;
        we_sel         = owner_q == OWN_LSU ? bus.lsu_we    : bus.if_we;
        wstrb_sel      = owner_q == OWN_LSU ? bus.lsu_wstrb : bus.if_wstrb;
        wdata_sel      = owner_q == OWN_LSU ? bus.lsu_wdata : bus.if_wdata;
        bus.mem_req    = state_q == ADDR && own_req;
        bus.mem_addr   = bus.mem_req ? addr_sel  : '0;
        bus.mem_we     = bus.mem_req ? we_sel    : 1'b0;
        bus.mem_wstrb  = bus.mem_req ? wstrb_sel : '0;
        bus.mem_wdata  = bus.mem_req ? wdata_sel : '0;
        own_gnt        = bus.mem_req && bus.mem_gnt;
        own_rvalid     = state_q == RESP && (bus.mem_rvalid || tmr_exp);
        own_err        = own_rvalid && !bus.mem_rvalid;
        own_rdata      = (own_rvalid && bus.mem_rvalid) ? bus.mem_rdata : '0;
        bus.if_gnt     = own_gnt    && owner_q == OWN_IF;
        bus.if_rvalid  = own_rvalid && owner_q == OWN_IF;
        bus.if_err     = own_err    && owner_q == OWN_IF;
        bus.if_rdata   = owner_q == OWN_IF ? own_rdata : '0;
        bus.lsu_gnt    = own_gnt    && owner_q == OWN_LSU;
        bus.lsu_rvalid = own_rvalid && owner_q == OWN_LSU;
        bus.lsu_err    = own_err    && owner_q == OWN_LSU;
        bus.lsu_rdata  = owner_q == OWN_LSU ? own_rdata : '0;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            IDLE: if (bus.if_req || bus.lsu_req) begin
                owner_d = (bus.if_req && bus.lsu_req) ? (last_q == OWN_IF ? OWN_LSU : OWN_IF)
                                                      : (bus.lsu_req ? OWN_LSU : OWN_IF);
                last_d  = owner_d;
                state_d = ADDR;
            end
            ADDR: if (!own_req) state_d = IDLE;
                  else if (bus.mem_gnt) begin
                      state_d = RESP;
                      tmr_clr = 1'b1;
                  end
            RESP: begin
                tmr_en = 1'b1;
                if (own_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rv_namec_mem_arbiter_clock or negedge rv_namec_mem_arbiter_reset_n) begin
        if (!rv_namec_mem_arbiter_reset_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            last_q  <= OWN_IF;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    rv_namec_bus_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk_i   (rv_namec_mem_arbiter_clock),
        .rst_ni  (rv_namec_mem_arbiter_reset_n),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .expire_o(tmr_exp)
    );

endmodule

// File: tb/tb_rv_namec_mem_arbiter.sv
// tb_rv_namec_mem_arbiter: scenario tasks with a response scoreboard checked by a negedge monitor.
module tb_rv_namec_mem_arbiter;

    typedef struct packed {
        logic        lsu;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    rv_namec_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    rv_namec_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .rv_namec_mem_arbiter_clock  (clk),
        .rv_namec_mem_arbiter_reset_n(rst_n),
        .bus                         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every response pulse must match the oldest expectation, with the other requester silent.
    always @(negedge clk) begin
        if (rst_n && (bus.if_rvalid || bus.lsu_rvalid)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: if_rvalid=%0b lsu_rvalid=%0b required none", bus.if_rvalid, bus.lsu_rvalid);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.lsu_rvalid, bus.if_rvalid,
                     mon_e.lsu ? bus.lsu_rdata : bus.if_rdata,
                     mon_e.lsu ? bus.lsu_err   : bus.if_err,
                     mon_e.lsu ? bus.if_rdata  : bus.lsu_rdata,
                     mon_e.lsu ? bus.if_err    : bus.lsu_err}
                    !== {mon_e.lsu, !mon_e.lsu, mon_e.rdata, mon_e.err, 32'h0, 1'b0}) begin
                    errors++;
                    $display("FAIL response: lsu_rv=%0b if_rv=%0b if_rdata=%h if_err=%0b lsu_rdata=%h lsu_err=%0b required owner_lsu=%0b rdata=%h err=%0b",
                             bus.lsu_rvalid, bus.if_rvalid, bus.if_rdata, bus.if_err, bus.lsu_rdata, bus.lsu_err,
                             mon_e.lsu, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_addr = 0; bus.if_we = 0; bus.if_wstrb = 0; bus.if_wdata = 0;
        bus.lsu_req = 0; bus.lsu_addr = 0; bus.lsu_we = 0; bus.lsu_wstrb = 0; bus.lsu_wdata = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) cyc();
        rst_n = 1;
        cyc();
    endtask

    function automatic logic [169:0] all_outs();
        return {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_err,
                bus.lsu_gnt, bus.lsu_rvalid, bus.lsu_rdata, bus.lsu_err,
                bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata};
    endfunction

    // Caller is in IDLE; read with immediate mem_gnt and response rsp_dly cycles after the grant.
    task automatic simple_read(input logic lsu, input logic [31:0] addr, input int rsp_dly, input logic [31:0] rdata);
        if (lsu) begin bus.lsu_req = 1; bus.lsu_addr = addr; end
        else     begin bus.if_req  = 1; bus.if_addr  = addr; end
        cyc();
        bus.mem_gnt = 1;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.lsu_gnt, bus.if_gnt} !== {1'b1, addr, 1'b0, lsu, !lsu}) begin
            errors++;
            $display("FAIL read_grant: mem_req=%0b mem_addr=%h lsu_gnt=%0b if_gnt=%0b required addr=%h owner_lsu=%0b",
                     bus.mem_req, bus.mem_addr, bus.lsu_gnt, bus.if_gnt, addr, lsu);
        end
        cyc();
        bus.if_req = 0; bus.lsu_req = 0; bus.mem_gnt = 0;
        for (int d = 1; d < rsp_dly; d++) begin
            @(negedge clk);
            checks++;
            if ({bus.mem_req, bus.if_rvalid, bus.lsu_rvalid} !== 3'b000) begin
                errors++;
                $display("FAIL read_wait: mem_req=%0b if_rvalid=%0b lsu_rvalid=%0b required 0", bus.mem_req, bus.if_rvalid, bus.lsu_rvalid);
            end
            cyc();
        end
        bus.mem_rvalid = 1; bus.mem_rdata = rdata;
        exp_q.push_back('{lsu: lsu, rdata: rdata, err: 1'b0});
        @(negedge clk);
        checks++;
        if ((lsu ? bus.lsu_rvalid : bus.if_rvalid) !== 1'b1) begin
            errors++;
            $display("FAIL read_rvalid_timing: owner rvalid=0 required 1");
        end
        cyc();
        bus.mem_rvalid = 0; bus.mem_rdata = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        cyc();
        bus.if_req = 1; bus.lsu_req = 1; bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h required 0", all_outs());
        end
        cyc();
        idle_inputs();
        rst_n = 1;
        cyc();
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h required 0", all_outs());
        end
        cyc();
    endtask

    task automatic test_if_read();
        simple_read(1'b0, 32'h100, 2, 32'hDEAD_BEEF);
    endtask

    task automatic test_arb_alternate();
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h1000;
        bus.lsu_req = 1; bus.lsu_addr = 32'h2000;
        for (int i = 0; i < 8; i++) begin
            cyc();
            bus.mem_gnt = 1;
            @(negedge clk);
            checks++;
            if ({bus.lsu_gnt, bus.if_gnt, bus.mem_addr} !== (i % 2 == 0 ? {2'b10, 32'h2000} : {2'b01, 32'h1000})) begin
                errors++;
                $display("FAIL arb_order[%0d]: lsu_gnt=%0b if_gnt=%0b mem_addr=%h required %s", i,
                         bus.lsu_gnt, bus.if_gnt, bus.mem_addr, i % 2 == 0 ? "LSU" : "IF");
            end
            cyc();
            bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hA000_0000 + i;
            exp_q.push_back('{lsu: (i % 2 == 0), rdata: 32'hA000_0000 + i, err: 1'b0});
            cyc();
            bus.mem_rvalid = 0;
        end
        bus.if_req = 0; bus.lsu_req = 0;
        cyc();
    endtask

    task automatic test_lsu_write_delayed_gnt();
        int gcount = 0;
        bus.lsu_req = 1; bus.lsu_addr = 32'h200; bus.lsu_we = 1; bus.lsu_wstrb = 4'hF; bus.lsu_wdata = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus.mem_gnt = (k == 3);
            @(negedge clk);
            gcount += int'(bus.lsu_gnt);
            checks++;
            if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata}
                !== {1'b1, 32'h200, 1'b1, 4'hF, 32'h1234_5678}) begin
                errors++;
                $display("FAIL write_payload[%0d]: req=%0b addr=%h we=%0b wstrb=%h wdata=%h required 1/200/1/f/12345678", k,
                         bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata);
            end
        end
        cyc();
        bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_wstrb = 0; bus.lsu_wdata = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0BAD_F00D;
        exp_q.push_back('{lsu: 1'b1, rdata: 32'h0BAD_F00D, err: 1'b0});
        @(negedge clk);
        gcount += int'(bus.lsu_gnt);
        cyc();
        bus.mem_rvalid = 0;
        checks++;
        if (gcount != 1) begin
            errors++;
            $display("FAIL write_gnt_count: got %0d required 1", gcount);
        end
    endtask

    task automatic test_timeout();
        bus.lsu_req = 1; bus.lsu_addr = 32'h300;
        cyc();
        bus.mem_gnt = 1;
        @(negedge clk);
        checks++;
        if (bus.lsu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL timeout_gnt: lsu_gnt=%0b required 1", bus.lsu_gnt);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            bus.lsu_req = 0; bus.mem_gnt = 0;
            if (k == 8) exp_q.push_back('{lsu: 1'b1, rdata: 32'h0, err: 1'b1});
            @(negedge clk);
            checks++;
            if (bus.lsu_rvalid !== (k == 8)) begin
                errors++;
                $display("FAIL timeout_timing[%0d]: lsu_rvalid=%0b required %0b", k, bus.lsu_rvalid, k == 8);
            end
        end
        cyc();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        checks++;
        if ({bus.if_rvalid, bus.lsu_rvalid, bus.lsu_rdata} !== '0) begin
            errors++;
            $display("FAIL late_rvalid: if_rvalid=%0b lsu_rvalid=%0b lsu_rdata=%h required 0", bus.if_rvalid, bus.lsu_rvalid, bus.lsu_rdata);
        end
        cyc();
        bus.mem_rvalid = 0; bus.mem_rdata = 0;
    endtask

    task automatic test_reset_in_resp();
        bus.if_req = 1; bus.if_addr = 32'h440;
        cyc();
        bus.mem_gnt = 1;
        cyc();
        bus.if_req = 0; bus.mem_gnt = 0;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFE_0001;
        rst_n = 0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL async_reset: outputs=%h required 0", all_outs());
        end
        bus.mem_rvalid = 0; bus.mem_rdata = 0;
        cyc();
        rst_n = 1;
        cyc();
        simple_read(1'b0, 32'h480, 1, 32'h0000_1234);
    endtask

    task automatic test_abort();
        bus.if_req = 1; bus.if_addr = 32'h400;
        cyc();
        bus.if_req = 0; bus.lsu_req = 1; bus.lsu_addr = 32'h500;
        @(negedge clk);
        checks++;
        if (bus.if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_gnt: if_gnt=%0b required 0", bus.if_gnt);
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.if_gnt, bus.lsu_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle: mem_req=%0b if_gnt=%0b lsu_gnt=%0b required 0", bus.mem_req, bus.if_gnt, bus.lsu_gnt);
        end
        cyc();
        bus.mem_gnt = 1;
        @(negedge clk);
        checks++;
        if ({bus.lsu_gnt, bus.if_gnt, bus.mem_req, bus.mem_addr} !== {3'b101, 32'h500}) begin
            errors++;
            $display("FAIL abort_next_lsu: lsu_gnt=%0b if_gnt=%0b mem_req=%0b mem_addr=%h required 1/0/1/500",
                     bus.lsu_gnt, bus.if_gnt, bus.mem_req, bus.mem_addr);
        end
        cyc();
        bus.lsu_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0500;
        exp_q.push_back('{lsu: 1'b1, rdata: 32'h0000_0500, err: 1'b0});
        cyc();
        bus.mem_rvalid = 0; bus.mem_rdata = 0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_arb_alternate();
        test_lsu_write_delayed_gnt();
        test_timeout();
        test_reset_in_resp();
        test_abort();
        repeat (2) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_responses: %0d outstanding required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
